// File: rtl/increment_param_if.sv
// Control and status bundle for the increment_param sequencing counter.
// The master side (controller/bench) drives the controls and reads the count;
// the slave side is the counter itself.
interface increment_param_if #(
    parameter int WIDTH = 5
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] limit;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] t;
    logic             dir;
    logic             tc;

    modport master (
        output en, mode, step, limit, load, load_val,
        input  t, dir, tc
    );

    modport slave (
        input  en, mode, step, limit, load, load_val,
        output t, dir, tc
    );
endinterface

// File: rtl/increment_param.sv
// Programmable sequencing counter: step, inclusive upper limit, synchronous
// load, enable, and four count modes (up-wrap, down-wrap, up-saturate,
// bounce) with a registered direction flag and a one-cycle terminal pulse.
//
// Direction FSM (only bounce mode steers it both ways; the other modes
// force it, load/clamp/step=0/idle leave it untouched):
//   state | meaning
//   UP    | counting toward limit, dir=1 (reset state)
//   DOWN  | counting toward 0, dir=0
module increment_param #(
    parameter int WIDTH = 5
) (
    input  logic                clk,
    input  logic                resetn,
    increment_param_if.slave    bus
);
    localparam int W1 = WIDTH + 1;

    typedef enum logic {
        DOWN = 1'b0,
        UP   = 1'b1
    } dir_e;

    logic [WIDTH-1:0] t_q;
    logic [WIDTH-1:0] t_d;
    dir_e             dir_q;
    dir_e             dir_d;
    logic             tc_q;
    logic             tc_d;

    // One guard bit so t+step and limit+1 never wrap inside the compares.
    logic [W1-1:0] t_x;
    logic [W1-1:0] step_x;
    logic [W1-1:0] lim_x;
    logic [W1-1:0] lim1_x;
    logic [W1-1:0] ldv_x;
    logic [W1-1:0] sum_x;

    assign t_x    = {1'b0, t_q};
    assign step_x = {1'b0, bus.step};
    assign lim_x  = {1'b0, bus.limit};
    assign ldv_x  = {1'b0, bus.load_val};
    assign lim1_x = lim_x + W1'(1);
    assign sum_x  = t_x + step_x;

    // State register: count, direction and terminal pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            t_q   <= '0;
            dir_q <= UP;
            tc_q  <= 1'b0;
        end else begin
            t_q   <= t_d;
            dir_q <= dir_d;
            tc_q  <= tc_d;
        end
    end

    // Next count/direction/pulse: load beats clamp beats counting.
    always_comb begin
        t_d   = t_q;
        dir_d = dir_q;
        tc_d  = 1'b0;

        if (bus.load) begin
            t_d = (ldv_x > lim_x) ? bus.limit : bus.load_val;
        end else if (bus.en) begin
            if (t_x > lim_x) begin
                // limit was lowered below the current count
                t_d = bus.limit;
            end else if (step_x != '0) begin
                case (bus.mode)
                    2'b00: begin
                        dir_d = UP;
                        tc_d  = 1'b1;
                        if (step_x > lim1_x) begin
                            t_d = '0;
                        end else if (sum_x <= lim_x) begin
                            t_d  = WIDTH'(sum_x);
                            tc_d = 1'b0;
                        end else begin
                            t_d = WIDTH'(sum_x - lim1_x);
                        end
                    end
                    2'b01: begin
                        dir_d = DOWN;
                        tc_d  = 1'b1;
                        if (step_x > lim1_x) begin
                            t_d = bus.limit;
                        end else if (t_x >= step_x) begin
                            t_d  = WIDTH'(t_x - step_x);
                            tc_d = 1'b0;
                        end else begin
                            t_d = WIDTH'(t_x + lim1_x - step_x);
                        end
                    end
                    2'b10: begin
                        dir_d = UP;
                        if (t_x == lim_x) begin
                            t_d = t_q;
                        end else if (sum_x >= lim_x) begin
                            // pulse only on the edge that reaches the limit
                            t_d  = bus.limit;
                            tc_d = 1'b1;
                        end else begin
                            t_d = WIDTH'(sum_x);
                        end
                    end
                    2'b11: begin
                        if (dir_q == UP) begin
                            if (sum_x >= lim_x) begin
                                t_d   = bus.limit;
                                dir_d = DOWN;
                                tc_d  = 1'b1;
                            end else begin
                                t_d = WIDTH'(sum_x);
                            end
                        end else begin
                            if (t_x <= step_x) begin
                                t_d   = '0;
                                dir_d = UP;
                                tc_d  = 1'b1;
                            end else begin
                                t_d = WIDTH'(t_x - step_x);
                            end
                        end
                    end
                    default: begin
                        t_d = t_q;
                    end
                endcase
            end
        end
    end

    assign bus.t   = t_q;
    assign bus.dir = dir_q;
    assign bus.tc  = tc_q;
endmodule

// File: tb/tb_increment_param.sv
// Bench for increment_param: directed vector table, hand sequences for reset
// and load corners, then randomized traffic against an arithmetic model.
module tb_increment_param;
    localparam int W = 5;

    logic clk = 1'b0;
    logic resetn = 1'b1;

    increment_param_if #(.WIDTH(W)) bus ();

    increment_param #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic [1:0]   mode;
        logic [W-1:0] step;
        logic [W-1:0] limit;
        logic         load;
        logic [W-1:0] load_val;
        logic [W-1:0] exp_t;
        logic         exp_dir;
        logic         exp_tc;
    } vec_t;

    vec_t vecs[$];

    int n_cmp = 0;
    int n_bad = 0;

    // reference state
    int m_t   = 0;
    bit m_dir = 1'b1;
    bit m_tc  = 1'b0;

    task automatic add(input logic en, input logic [1:0] mode, input int step,
                       input int limit, input logic load, input int load_val,
                       input int exp_t, input logic exp_dir, input logic exp_tc);
        vec_t v;
        v.en = en; v.mode = mode; v.step = W'(step); v.limit = W'(limit);
        v.load = load; v.load_val = W'(load_val);
        v.exp_t = W'(exp_t); v.exp_dir = exp_dir; v.exp_tc = exp_tc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [W-1:0] et,
                         input logic ed, input logic etc);
        n_cmp++;
        if (bus.t !== et || bus.dir !== ed || bus.tc !== etc) begin
            n_bad++;
            $display("FAIL %s @%0t: got t=%0d dir=%0b tc=%0b, want t=%0d dir=%0b tc=%0b",
                     name, $time, bus.t, bus.dir, bus.tc, et, ed, etc);
        end
    endtask

    // Model of one rising edge from the rules, in plain integer arithmetic.
    task automatic model_edge();
        int t, s, l, nt;
        t = m_t;
        s = int'(bus.step);
        l = int'(bus.limit);
        m_tc = 1'b0;
        if (bus.load) begin
            m_t = (int'(bus.load_val) < l) ? int'(bus.load_val) : l;
        end else if (bus.en) begin
            if (t > l) begin
                m_t = l;
            end else if (s != 0) begin
                case (bus.mode)
                    2'd0: begin
                        m_dir = 1'b1;
                        if (s > l + 1) begin
                            m_t = 0; m_tc = 1'b1;
                        end else begin
                            m_t = (t + s) % (l + 1);
                            m_tc = (t + s > l);
                        end
                    end
                    2'd1: begin
                        m_dir = 1'b0;
                        if (s > l + 1) begin
                            m_t = l; m_tc = 1'b1;
                        end else begin
                            m_t = (((t - s) % (l + 1)) + (l + 1)) % (l + 1);
                            m_tc = (t < s);
                        end
                    end
                    2'd2: begin
                        m_dir = 1'b1;
                        if (t != l) begin
                            nt = (t + s >= l) ? l : t + s;
                            m_t = nt;
                            m_tc = (nt == l);
                        end
                    end
                    default: begin
                        if (m_dir) begin
                            if (t + s >= l) begin
                                m_t = l; m_dir = 1'b0; m_tc = 1'b1;
                            end else begin
                                m_t = t + s;
                            end
                        end else begin
                            if (t <= s) begin
                                m_t = 0; m_dir = 1'b1; m_tc = 1'b1;
                            end else begin
                                m_t = t - s;
                            end
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_t = 0; m_dir = 1'b1; m_tc = 1'b0;
    endtask

    task automatic set_in(input logic en, input logic [1:0] mode, input int step,
                          input int limit, input logic load, input int load_val);
        bus.en = en; bus.mode = mode; bus.step = W'(step); bus.limit = W'(limit);
        bus.load = load; bus.load_val = W'(load_val);
    endtask

    initial begin
        // plan 2: up-wrap limit 9 step 3, then idle
        add(1, 2'd0, 3, 9, 0, 0, 3, 1, 0);
        add(1, 2'd0, 3, 9, 0, 0, 6, 1, 0);
        add(1, 2'd0, 3, 9, 0, 0, 9, 1, 0);
        add(1, 2'd0, 3, 9, 0, 0, 2, 1, 1);
        add(1, 2'd0, 3, 9, 0, 0, 5, 1, 0);
        add(1, 2'd0, 3, 9, 0, 0, 8, 1, 0);
        add(1, 2'd0, 3, 9, 0, 0, 1, 1, 1);
        add(0, 2'd0, 3, 9, 0, 0, 1, 1, 0);
        add(0, 2'd0, 3, 9, 0, 0, 1, 1, 0);
        add(0, 2'd0, 3, 9, 0, 0, 1, 1, 0);
        // plan 3: load 5, down-wrap limit 9 step 4
        add(0, 2'd1, 4, 9, 1, 5, 5, 1, 0);
        add(1, 2'd1, 4, 9, 0, 0, 1, 0, 0);
        add(1, 2'd1, 4, 9, 0, 0, 7, 0, 1);
        add(1, 2'd1, 4, 9, 0, 0, 3, 0, 0);
        add(1, 2'd1, 4, 9, 0, 0, 9, 0, 1);
        add(1, 2'd1, 4, 9, 0, 0, 5, 0, 0);
        // plan 4: up-saturate limit 20 step 7, then clamp to 12
        add(0, 2'd2, 7, 20, 1, 0, 0, 0, 0);
        add(1, 2'd2, 7, 20, 0, 0, 7, 1, 0);
        add(1, 2'd2, 7, 20, 0, 0, 14, 1, 0);
        add(1, 2'd2, 7, 20, 0, 0, 20, 1, 1);
        add(1, 2'd2, 7, 20, 0, 0, 20, 1, 0);
        add(1, 2'd2, 7, 20, 0, 0, 20, 1, 0);
        add(1, 2'd2, 7, 12, 0, 0, 12, 1, 0);
        // plan 5: bounce limit 10 step 4
        add(0, 2'd3, 4, 10, 1, 0, 0, 1, 0);
        add(1, 2'd3, 4, 10, 0, 0, 4, 1, 0);
        add(1, 2'd3, 4, 10, 0, 0, 8, 1, 0);
        add(1, 2'd3, 4, 10, 0, 0, 10, 0, 1);
        add(1, 2'd3, 4, 10, 0, 0, 6, 0, 0);
        add(1, 2'd3, 4, 10, 0, 0, 2, 0, 0);
        add(1, 2'd3, 4, 10, 0, 0, 0, 1, 1);
        add(1, 2'd3, 4, 10, 0, 0, 4, 1, 0);
        // oversized step, step=0, limit=0 bounce, back-to-back pulses
        add(1, 2'd0, 11, 9, 0, 0, 0, 1, 1);
        add(1, 2'd1, 11, 9, 0, 0, 9, 0, 1);
        add(1, 2'd0, 0, 9, 0, 0, 9, 0, 0);
        add(1, 2'd3, 2, 0, 0, 0, 0, 0, 0);
        add(1, 2'd3, 2, 0, 0, 0, 0, 1, 1);
        add(1, 2'd3, 2, 0, 0, 0, 0, 0, 1);
        add(1, 2'd3, 2, 0, 0, 0, 0, 1, 1);
        add(0, 2'd0, 5, 4, 1, 3, 3, 1, 0);
        add(1, 2'd0, 5, 4, 0, 0, 3, 1, 1);
        add(1, 2'd0, 5, 4, 0, 0, 3, 1, 1);

        set_in(0, 2'd0, 1, 31, 0, 0);
        #2 resetn = 1'b0;
        #1 check("reset_async", '0, 1'b1, 1'b0);
        model_reset();
        #9 resetn = 1'b1;               // released at t=12, between edges

        // plan 1: legacy 5-bit incrementer sequence
        set_in(1, 2'd0, 1, 31, 0, 0);
        for (int i = 0; i < 33; i++) begin
            tick();
            check("legacy_seq", W'((i + 1) % 32), 1'b1, (i == 31));
        end

        // plans 2-5 and corners from a fresh reset
        resetn = 1'b0;
        #1 check("reset_hold", '0, 1'b1, 1'b0);
        model_reset();
        @(posedge clk);
        #3 resetn = 1'b1;
        foreach (vecs[i]) begin
            set_in(vecs[i].en, vecs[i].mode, int'(vecs[i].step), int'(vecs[i].limit),
                   vecs[i].load, int'(vecs[i].load_val));
            tick();
            check($sformatf("vec%0d", i), vecs[i].exp_t, vecs[i].exp_dir, vecs[i].exp_tc);
        end

        // plan 6: load beats enable and is clamped; async reset mid-count
        set_in(1, 2'd0, 1, 20, 1, 25);
        tick();
        check("load_clamp", W'(20), 1'b1, 1'b0);
        set_in(1, 2'd0, 1, 31, 0, 0);
        tick();
        check("count_21", W'(21), 1'b1, 1'b0);
        tick();
        check("count_22", W'(22), 1'b1, 1'b0);
        #3 resetn = 1'b0;
        #1 check("reset_mid", '0, 1'b1, 1'b0);
        model_reset();
        @(posedge clk);
        #1 check("reset_held_edge", '0, 1'b1, 1'b0);
        #3 resetn = 1'b1;
        tick();
        check("resume_1", W'(1), 1'b1, 1'b0);
        tick();
        check("resume_2", W'(2), 1'b1, 1'b0);

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            bus.load     = ($urandom_range(0, 15) == 0);
            bus.load_val = W'($urandom);
            bus.en       = ($urandom_range(0, 3) != 0);
            bus.mode     = 2'($urandom);
            if ($urandom_range(0, 7) == 0) bus.step = W'($urandom);
            else                           bus.step = W'($urandom_range(0, 4));
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 4) == 0) bus.limit = '0;
                else                           bus.limit = W'($urandom);
            end
            tick();
            check("random", W'(m_t), m_dir, m_tc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
